// File: rtl/alu_result_checker.sv
// Sweep-based checker for a 16-opcode 8-bit ALU: follows the registered opcode/result
// stream, recomputes each result from A/B and reports per-sweep mismatch statistics.
module alu_result_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic [3:0]       ALU_Sel,
  input  logic [7:0]       ALU_Out,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_mask,
  output logic [4:0]       err_cnt,
  output logic [CNT_W-1:0] sweep_cnt,
  output logic             seq_err
);

  // state | meaning
  // IDLE  | out of reset, waiting for the first enabled cycle
  // SYNC  | hunting for ALU_Sel==1 (op 0 result) to open a sweep
  // CHECK | inside a sweep; r_exp_sel is the next required ALU_Sel
  typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;

  state_t           r_state, w_state;
  logic [3:0]       r_exp_sel, w_exp_sel;
  logic [7:0]       r_a, r_b, w_a, w_b;
  logic             r_done, w_done;
  logic             r_pass, w_pass;
  logic             r_seq_err, w_seq_err;
  logic [15:0]      r_err_mask, w_err_mask;
  logic [4:0]       r_err_cnt, w_err_cnt;
  logic [CNT_W-1:0] r_sweep_cnt, w_sweep_cnt;

  logic [3:0]       w_op;
  logic [7:0]       w_expect;
  logic             w_miss;
  logic [4:0]       w_cnt_inc;
  logic             w_start;

  function automatic logic [7:0] f_expect(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    case (op)
      4'd0:    return a + 8'd1;
      4'd1:    return a + b;
      4'd2:    return a - 8'd1;
      4'd3:    return a - b;
      4'd4:    return a * b;
      4'd5:    return {7'd0, a == b};
      4'd6:    return {7'd0, a > b};
      4'd7:    return {7'd0, a < b};
      4'd8:    return ~a;
      4'd9:    return a & b;
      4'd10:   return a | b;
      4'd11:   return ~(a & b);
      4'd12:   return ~(a | b);
      4'd13:   return a ^ b;
      4'd14:   return a >> 1;
      default: return a << 1;
    endcase
  endfunction

  // The sample carries the result of the opcode one behind ALU_Sel.
  assign w_op      = ALU_Sel - 4'd1;
  assign w_expect  = f_expect(w_op, A, B);
  assign w_miss    = (ALU_Out != w_expect);
  assign w_cnt_inc = r_err_cnt + {4'd0, w_miss};
  assign w_start   = (ALU_Sel == 4'd1) &&
                     ((r_state == SYNC) || (r_state == CHECK && r_exp_sel == 4'd1));

  always_comb begin
    w_state     = r_state;
    w_exp_sel   = r_exp_sel;
    w_a         = r_a;
    w_b         = r_b;
    w_done      = 1'b0;
    w_pass      = r_pass;
    w_seq_err   = r_seq_err;
    w_err_mask  = r_err_mask;
    w_err_cnt   = r_err_cnt;
    w_sweep_cnt = r_sweep_cnt;
    if (en) begin
      if (w_start) begin
        w_state    = CHECK;
        w_exp_sel  = 4'd2;
        w_a        = A;
        w_b        = B;
        w_err_mask = {15'd0, w_miss};
        w_err_cnt  = {4'd0, w_miss};
      end else begin
        case (r_state)
          IDLE: w_state = SYNC;
          CHECK: begin
            if (ALU_Sel != r_exp_sel || A != r_a || B != r_b) begin
              w_seq_err = 1'b1;
              w_state   = SYNC;
            end else begin
              w_exp_sel = r_exp_sel + 4'd1;
              w_err_cnt = w_cnt_inc;
              if (w_miss) w_err_mask[w_op] = 1'b1;
              if (ALU_Sel == 4'd0) begin
                w_done      = 1'b1;
                w_pass      = (w_cnt_inc == 5'd0);
                w_sweep_cnt = r_sweep_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_exp_sel   <= 4'd0;
      r_a         <= 8'd0;
      r_b         <= 8'd0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_seq_err   <= 1'b0;
      r_err_mask  <= 16'd0;
      r_err_cnt   <= 5'd0;
      r_sweep_cnt <= '0;
    end else begin
      r_state     <= w_state;
      r_exp_sel   <= w_exp_sel;
      r_a         <= w_a;
      r_b         <= w_b;
      r_done      <= w_done;
      r_pass      <= w_pass;
      r_seq_err   <= w_seq_err;
      r_err_mask  <= w_err_mask;
      r_err_cnt   <= w_err_cnt;
      r_sweep_cnt <= w_sweep_cnt;
    end
  end

  assign done      = r_done;
  assign pass      = r_pass;
  assign err_mask  = r_err_mask;
  assign err_cnt   = r_err_cnt;
  assign sweep_cnt = r_sweep_cnt;
  assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: plays the ALU from hand-computed sweep tables
// and checks sweep statistics, sequence-error handling, enable hold and reset.
module tb_alu_result_checker;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, en;
  logic [7:0]       A, B, ALU_Out;
  logic [3:0]       ALU_Sel;
  logic             done, pass, seq_err;
  logic [15:0]      err_mask;
  logic [4:0]       err_cnt;
  logic [CNT_W-1:0] sweep_cnt;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  int exp_sw = 0;

  alu_result_checker #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out),
    .done(done), .pass(pass), .err_mask(err_mask), .err_cnt(err_cnt),
    .sweep_cnt(sweep_cnt), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) n_done++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // res[k] is the ALU result of opcode k; ops with fault[k] set are driven inverted
  typedef struct packed {
    logic [7:0]        a;
    logic [7:0]        b;
    logic [0:15][7:0]  res;
    logic [15:0]       fault;
    logic              exp_pass;
    logic [15:0]       exp_mask;
    logic [4:0]        exp_cnt;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                        input logic [7:0] out);
    en = 1'b1; A = a; B = b; ALU_Sel = sel; ALU_Out = out;
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_pass"}, {31'd0, pass}, 0);
    chk({tag, "_mask"}, {16'd0, err_mask}, 0);
    chk({tag, "_cnt"}, {27'd0, err_cnt}, 0);
    chk({tag, "_sweep"}, {24'd0, sweep_cnt}, 0);
    chk({tag, "_seq"}, {31'd0, seq_err}, 0);
  endtask

  task automatic run_sweep(input vec_t v, input int gap_at, input logic exp_seq);
    for (int k = 0; k < 16; k++) begin
      if (k == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          en = 1'b0; A = 8'($urandom); ALU_Sel = 4'($urandom); ALU_Out = 8'($urandom);
          step();
          chk("gap_done", {31'd0, done}, 0);
        end
      end
      sample(v.a, v.b, 4'(k + 1), v.res[k] ^ (v.fault[k] ? 8'hFF : 8'h00));
      if (k == 14) chk("done_early", {31'd0, done}, 0);
    end
    exp_sw++;
    chk("done", {31'd0, done}, 1);
    chk("pass", {31'd0, pass}, {31'd0, v.exp_pass});
    chk("err_mask", {16'd0, err_mask}, {16'd0, v.exp_mask});
    chk("err_cnt", {27'd0, err_cnt}, {27'd0, v.exp_cnt});
    chk("sweep_cnt", {24'd0, sweep_cnt}, 32'(exp_sw % 256));
    chk("seq_err", {31'd0, seq_err}, {31'd0, exp_seq});
    en = 1'b0;
    step();
    chk("done_width", {31'd0, done}, 0);
    chk("mask_hold", {16'd0, err_mask}, {16'd0, v.exp_mask});
  endtask

  initial begin
    vecs[0] = '{a: 8'h0C, b: 8'h05,
                res: {8'h0D, 8'h11, 8'h0B, 8'h07, 8'h3C, 8'h00, 8'h01, 8'h00,
                      8'hF3, 8'h04, 8'h0D, 8'hFB, 8'hF2, 8'h09, 8'h06, 8'h18},
                fault: 16'h0000, exp_pass: 1'b1, exp_mask: 16'h0000, exp_cnt: 5'd0};
    vecs[1] = '{a: 8'hFF, b: 8'h01,
                res: {8'h00, 8'h00, 8'hFE, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h00,
                      8'h00, 8'h01, 8'hFF, 8'hFE, 8'h00, 8'hFE, 8'h7F, 8'hFE},
                fault: 16'h0000, exp_pass: 1'b1, exp_mask: 16'h0000, exp_cnt: 5'd0};
    vecs[2] = vecs[0];
    vecs[2].fault = 16'h0010; vecs[2].exp_pass = 1'b0;
    vecs[2].exp_mask = 16'h0010; vecs[2].exp_cnt = 5'd1;
    vecs[3] = '{a: 8'h03, b: 8'h07,
                res: {8'h04, 8'h0A, 8'h02, 8'hFC, 8'h15, 8'h00, 8'h00, 8'h01,
                      8'hFC, 8'h03, 8'h07, 8'hFC, 8'hF8, 8'h04, 8'h01, 8'h06},
                fault: 16'h8001, exp_pass: 1'b0, exp_mask: 16'h8001, exp_cnt: 5'd2};
    vecs[4] = '{a: 8'h80, b: 8'h80,
                res: {8'h81, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
                      8'h7F, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h00, 8'h40, 8'h00},
                fault: 16'h0000, exp_pass: 1'b1, exp_mask: 16'h0000, exp_cnt: 5'd0};
    vecs[5] = '{a: 8'h00, b: 8'h00,
                res: {8'h01, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
                      8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00},
                fault: 16'hFFFF, exp_pass: 1'b0, exp_mask: 16'hFFFF, exp_cnt: 5'd16};
    vecs[6] = vecs[3];
    vecs[6].fault = 16'h0000; vecs[6].exp_pass = 1'b1;
    vecs[6].exp_mask = 16'h0000; vecs[6].exp_cnt = 5'd0;

    rst = 1'b1; en = 1'b0; A = 8'h00; B = 8'h00; ALU_Sel = 4'h0; ALU_Out = 8'h00;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    sample(8'h00, 8'h00, 4'h0, 8'h00);

    // table-driven back-to-back sweeps
    for (int i = 0; i < 7; i++) run_sweep(vecs[i], -1, 1'b0);

    // opcode skip 5 -> 7, with a partial mismatch on op 2 before the break
    for (int k = 0; k < 5; k++)
      sample(8'h0C, 8'h05, 4'(k + 1), vecs[0].res[k] ^ ((k == 2) ? 8'hFF : 8'h00));
    sample(8'h0C, 8'h05, 4'd7, vecs[0].res[6]);
    chk("skip_seq", {31'd0, seq_err}, 1);
    chk("skip_done", {31'd0, done}, 0);
    chk("skip_sweep", {24'd0, sweep_cnt}, 32'(exp_sw));
    chk("skip_mask", {16'd0, err_mask}, 32'h0004);
    chk("skip_cnt", {27'd0, err_cnt}, 1);
    sample(8'h0C, 8'h05, 4'd3, 8'h55);
    chk("sync_ignore", {31'd0, done}, 0);
    run_sweep(vecs[0], -1, 1'b1);

    // operand change mid-sweep abandons it; tail of the stream must not complete
    for (int k = 0; k < 6; k++) sample(8'h80, 8'h80, 4'(k + 1), vecs[4].res[k]);
    sample(8'h81, 8'h80, 4'd7, vecs[4].res[6]);
    chk("abchg_done", {31'd0, done}, 0);
    for (int k = 7; k < 16; k++) sample(8'h80, 8'h80, 4'(k + 1), vecs[4].res[k]);
    chk("abchg_tail_done", {31'd0, done}, 0);
    chk("abchg_sweep", {24'd0, sweep_cnt}, 32'(exp_sw));

    // three sweeps, enable dropped for 3 cycles inside the second
    begin
      int d0;
      d0 = n_done;
      run_sweep(vecs[1], -1, 1'b1);
      run_sweep(vecs[4], 8, 1'b1);
      run_sweep(vecs[6], -1, 1'b1);
      chk("en_gap_pulses", 32'(n_done - d0), 3);
    end

    // reset at op 8, then the stale tail must not complete a sweep
    for (int k = 0; k < 8; k++) sample(8'h0C, 8'h05, 4'(k + 1), vecs[0].res[k]);
    rst = 1'b1;
    sample(8'h0C, 8'h05, 4'd9, vecs[0].res[8]);
    rst = 1'b0;
    chk_all_zero("midrst");
    exp_sw = 0;
    for (int k = 9; k < 16; k++) sample(8'h0C, 8'h05, 4'(k + 1), vecs[0].res[k]);
    chk("postrst_done", {31'd0, done}, 0);
    chk("postrst_sweep", {24'd0, sweep_cnt}, 0);
    run_sweep(vecs[0], -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
